// File: rtl/xidoo_pkg.sv
// Shared definitions for the fetch front end.
package xidoo_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/MuxN_2_1.sv
// Generic N-bit 2:1 multiplexer: out = sel ? in_1 : in_0.
module MuxN_2_1 #(
  parameter int unsigned N = 8
) (
  input  logic         sel,
  input  logic [N-1:0] in_0,
  input  logic [N-1:0] in_1,
  output logic [N-1:0] out
);

  always_comb begin
    out = in_0;
    if (sel) out = in_1;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and fetch-request stage: sequential stepping, redirects from
// execute, valid/ready fetch handshake and a saturating accepted-fetch counter.
module fetch_pc_unit
  import xidoo_pkg::*;
#(
  parameter int unsigned   N        = 8,
  parameter int unsigned   STEP     = 1,
  parameter logic [N-1:0]  RESET_PC = '0,
  parameter int unsigned   CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [N-1:0]     redirect_pc,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [N-1:0]     fetch_pc,
  output logic [N-1:0]     seq_pc,
  output logic             seq_wrap,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_t state, state_next;
  logic [N-1:0] pc;
  logic [N-1:0] pc_next;
  logic [N:0]   sum;
  logic         accept;

  assign accept   = fetch_valid & fetch_ready;
  assign fetch_pc = pc;

  always_comb begin
    sum      = {1'b0, pc} + (N+1)'(STEP);
    seq_pc   = sum[N-1:0];
    seq_wrap = sum[N];
  end

  // With sel low the mux never looks at redirect_pc, so X there stays contained.
  MuxN_2_1 #(.N(N)) u_next_pc_mux (
    .sel  (redirect_valid),
    .in_0 (seq_pc),
    .in_1 (redirect_pc),
    .out  (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (accept || redirect_valid) begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    fetch_valid = 1'b0;
    unique case (state)
      S_BOOT: begin
        state_next = redirect_valid ? S_FLUSH : S_FETCH;
      end
      S_FETCH: begin
        fetch_valid = 1'b1;
        if (redirect_valid) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        state_next = redirect_valid ? S_FLUSH : S_FETCH;
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (accept && (fetch_count != '1)) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit (default build plus a
// RESET_PC=0xFE / CNT_W=2 build for wrap and counter saturation).
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: N=8, STEP=1, RESET_PC=0, CNT_W=16
  logic        rst_n;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [7:0]  fetch_pc;
  logic [7:0]  seq_pc;
  logic        seq_wrap;
  logic [15:0] fetch_count;

  // Wrap/saturation instance: RESET_PC=0xFE, CNT_W=2
  logic        rst2_n;
  logic        redirect2_valid;
  logic [7:0]  redirect2_pc;
  logic        fetch2_ready;
  logic        fetch2_valid;
  logic [7:0]  fetch2_pc;
  logic [7:0]  seq2_pc;
  logic        seq2_wrap;
  logic [1:0]  fetch2_count;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  fetch_pc_unit #(.N(8), .STEP(1), .RESET_PC(8'h00), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .seq_pc         (seq_pc),
    .seq_wrap       (seq_wrap),
    .fetch_count    (fetch_count)
  );

  fetch_pc_unit #(.N(8), .STEP(1), .RESET_PC(8'hFE), .CNT_W(2)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst2_n),
    .redirect_valid (redirect2_valid),
    .redirect_pc    (redirect2_pc),
    .fetch_ready    (fetch2_ready),
    .fetch_valid    (fetch2_valid),
    .fetch_pc       (fetch2_pc),
    .seq_pc         (seq2_pc),
    .seq_wrap       (seq2_wrap),
    .fetch_count    (fetch2_count)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; fetch_ready = 1'b1;
    rst2_n = 1'b0; redirect2_valid = 1'b0; redirect2_pc = 8'h00; fetch2_ready = 1'b1;
    tick(); tick();
    total++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", fetch_valid); else pass_cnt++;
    total++; if (fetch_pc !== 8'h00) $display("FAIL reset_pc got=%h exp=00", fetch_pc); else pass_cnt++;
    total++; if (fetch_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", fetch_count); else pass_cnt++;
    total++; if (seq_pc !== 8'h01) $display("FAIL reset_seq_pc got=%h exp=01", seq_pc); else pass_cnt++;
    total++; if (seq_wrap !== 1'b0) $display("FAIL reset_seq_wrap got=%0b exp=0", seq_wrap); else pass_cnt++;
    total++; if (fetch2_pc !== 8'hFE) $display("FAIL reset2_pc got=%h exp=fe", fetch2_pc); else pass_cnt++;
    total++; if (seq2_pc !== 8'hFF) $display("FAIL reset2_seq_pc got=%h exp=ff", seq2_pc); else pass_cnt++;
  endtask

  task automatic test_run();
    logic [7:0] exp_pc;
    rst_n = 1'b1;
    total++; if (fetch_valid !== 1'b0) $display("FAIL boot_valid got=%0b exp=0", fetch_valid); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = 8'(i);
      total++; if (fetch_valid !== 1'b1 || fetch_pc !== exp_pc)
        $display("FAIL run_pc%0d got=%0b/%h exp=1/%h", i, fetch_valid, fetch_pc, exp_pc); else pass_cnt++;
    end
    tick();
    total++; if (fetch_count !== 16'd4) $display("FAIL run_count got=%0d exp=4", fetch_count); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    tick();
    fetch_ready = 1'b0;
    total++; if (fetch_pc !== 8'h05) $display("FAIL bp_start_pc got=%h exp=05", fetch_pc); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (fetch_valid !== 1'b1 || fetch_pc !== 8'h05 || fetch_count !== 16'd5)
        $display("FAIL bp_hold%0d got=%0b/%h/%0d exp=1/05/5", i, fetch_valid, fetch_pc, fetch_count); else pass_cnt++;
    end
    fetch_ready = 1'b1;
    tick();
    total++; if (fetch_pc !== 8'h06 || fetch_count !== 16'd6)
      $display("FAIL bp_release got=%h/%0d exp=06/6", fetch_pc, fetch_count); else pass_cnt++;
  endtask

  task automatic test_redirect_accept();
    for (int i = 0; i < 10; i++) tick();
    total++; if (fetch_pc !== 8'h10 || fetch_count !== 16'd16)
      $display("FAIL rd_pre got=%h/%0d exp=10/16", fetch_pc, fetch_count); else pass_cnt++;
    redirect_valid = 1'b1; redirect_pc = 8'h80;
    tick();
    redirect_valid = 1'b0; redirect_pc = 8'hxx;
    total++; if (fetch_valid !== 1'b0 || fetch_count !== 16'd17)
      $display("FAIL rd_bubble got=%0b/%0d exp=0/17", fetch_valid, fetch_count); else pass_cnt++;
    tick();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 8'h80 || fetch_count !== 16'd17)
      $display("FAIL rd_target got=%0b/%h/%0d exp=1/80/17", fetch_valid, fetch_pc, fetch_count); else pass_cnt++;
    tick();
    total++; if (fetch_pc !== 8'h81 || fetch_count !== 16'd18)
      $display("FAIL rd_step got=%h/%0d exp=81/18", fetch_pc, fetch_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    total++; if (fetch_valid !== 1'b0 || fetch_count !== 16'd18)
      $display("FAIL b2b_bubble1 got=%0b/%0d exp=0/18", fetch_valid, fetch_count); else pass_cnt++;
    fetch_ready = 1'b1; redirect_pc = 8'h90;
    tick();
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    total++; if (fetch_valid !== 1'b0) $display("FAIL b2b_bubble2 got=%0b exp=0", fetch_valid); else pass_cnt++;
    tick();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 8'h90 || fetch_count !== 16'd18)
      $display("FAIL b2b_first got=%0b/%h/%0d exp=1/90/18", fetch_valid, fetch_pc, fetch_count); else pass_cnt++;
    tick();
    total++; if (fetch_pc !== 8'h91 || fetch_count !== 16'd19)
      $display("FAIL b2b_step got=%h/%0d exp=91/19", fetch_pc, fetch_count); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    redirect_valid = 1'b1; redirect_pc = 8'h33;
    tick();
    redirect_valid = 1'b0;
    tick();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 8'h33 || fetch_count !== 16'd20)
      $display("FAIL mr_pre got=%0b/%h/%0d exp=1/33/20", fetch_valid, fetch_pc, fetch_count); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (fetch_valid !== 1'b0 || fetch_pc !== 8'h00 || fetch_count !== 16'd0 || seq_pc !== 8'h01)
      $display("FAIL mr_async got=%0b/%h/%0d/%h exp=0/00/0/01", fetch_valid, fetch_pc, fetch_count, seq_pc); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    total++; if (fetch_valid !== 1'b0) $display("FAIL mr_boot got=%0b exp=0", fetch_valid); else pass_cnt++;
    tick();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 8'h00)
      $display("FAIL mr_restart0 got=%0b/%h exp=1/00", fetch_valid, fetch_pc); else pass_cnt++;
    tick();
    total++; if (fetch_pc !== 8'h01 || fetch_count !== 16'd1)
      $display("FAIL mr_restart1 got=%h/%0d exp=01/1", fetch_pc, fetch_count); else pass_cnt++;
  endtask

  task automatic test_wrap_saturate();
    logic [7:0] exp_pc [5]   = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    logic       exp_wrap [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] exp_cnt [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    rst2_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (fetch2_valid !== 1'b1 || fetch2_pc !== exp_pc[i] || seq2_wrap !== exp_wrap[i] || fetch2_count !== exp_cnt[i])
        $display("FAIL wrap%0d got=%0b/%h/%0b/%0d exp=1/%h/%0b/%0d", i, fetch2_valid, fetch2_pc, seq2_wrap,
                 fetch2_count, exp_pc[i], exp_wrap[i], exp_cnt[i]); else pass_cnt++;
    end
    total++; if (seq2_pc !== 8'h03) $display("FAIL wrap_seq_pc got=%h exp=03", seq2_pc); else pass_cnt++;
    tick();
    total++; if (fetch2_count !== 2'd3 || fetch2_pc !== 8'h03)
      $display("FAIL sat_after5 got=%0d/%h exp=3/03", fetch2_count, fetch2_pc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_backpressure();
    test_redirect_accept();
    test_back_to_back();
    test_mid_reset();
    test_wrap_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
